// File: rtl/pattern_scan_engine_pkg.sv
// Shared types, default parameters and power-up ROM image for the pattern scan engine.
package pattern_scan_engine_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_NEXT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int DEF_WORD_W   = 8;
  localparam int DEF_PAT_W    = 4;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_COUNT_W  = 4;
  localparam int DEF_TICK_DIV = 1;

  // Active-low {a,b,c,d,e,f,g}; a lone middle bar for out-of-range counts.
  localparam logic [6:0] SEG_DASH = 7'b1111110;

  function automatic logic [7:0] rom_default(int idx);
    case (idx)
      0:       return 8'hB3;
      1:       return 8'h55;
      2:       return 8'hDB;
      3:       return 8'hD1;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/pattern_scan_engine_seg7.sv
// Active-low seven-segment decoder for 0-9; anything else shows a dash.
module seg7_decoder
  import pattern_scan_engine_pkg::*;
(
  input  logic [3:0] din_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       d_o,
  output logic       e_o,
  output logic       f_o,
  output logic       g_o
);

  logic [6:0] seg;

  always_comb begin
    seg = SEG_DASH;
    case (din_i)
      4'd0: seg = 7'b0000001;
      4'd1: seg = 7'b1001111;
      4'd2: seg = 7'b0010010;
      4'd3: seg = 7'b0000110;
      4'd4: seg = 7'b1001100;
      4'd5: seg = 7'b0100100;
      4'd6: seg = 7'b0100000;
      4'd7: seg = 7'b0001111;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0000100;
      default: seg = SEG_DASH;
    endcase
  end

  assign {a_o, b_o, c_o, d_o, e_o, f_o, g_o} = seg;

endmodule

// File: rtl/pattern_scan_engine.sv
// Scans every word of a small writable ROM for a sliding bit pattern and counts hits.
module pattern_scan_engine
  import pattern_scan_engine_pkg::*;
#(
  parameter int WORD_W   = DEF_WORD_W,
  parameter int PAT_W    = DEF_PAT_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int COUNT_W  = DEF_COUNT_W,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic [PAT_W-1:0]   pattern_i,
  input  logic               wr_en_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [WORD_W-1:0]  wr_data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [COUNT_W-1:0] match_count_o,
  output logic               overflow_o,
  output logic               a_o,
  output logic               b_o,
  output logic               c_o,
  output logic               d_o,
  output logic               e_o,
  output logic               f_o,
  output logic               g_o
);

  localparam int LAST_WIN = WORD_W - PAT_W;
  localparam int WIN_W    = (LAST_WIN > 0) ? $clog2(LAST_WIN + 1) : 1;
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [PAT_W-1:0]     pat_q, pat_d;
  logic                 mode_q, mode_d;

  logic [DEPTH-1:0][WORD_W-1:0] rom_words;
  logic [WORD_W-1:0]            shifted;
  logic                         rom_we, tick, hit;

  assign rom_we = wr_en_i && (state_q == S_IDLE);

  // ROM words are power-up initialised only; reset deliberately leaves them alone.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    logic [WORD_W-1:0] word_q = WORD_W'(rom_default(gi));
    always_ff @(posedge clk_i) begin
      if (rom_we && (wr_addr_i == ADDR_W'(gi))) word_q <= wr_data_i;
    end
    assign rom_words[gi] = word_q;
  end

  assign shifted = rom_words[addr_q] >> win_q;
  assign hit     = (shifted[PAT_W-1:0] == pat_q);
  assign tick    = (div_q == DIV_W'(TICK_DIV - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    win_d   = win_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    pat_d   = pat_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pat_d   = pattern_i;
          mode_d  = mode_i;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          addr_d  = '0;
          win_d   = '0;
          div_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (tick) begin
          div_d = '0;
          win_d = win_q + 1'b1;
          if (hit) begin
            if (&cnt_q) ovf_d = 1'b1;
            else        cnt_d = cnt_q + 1'b1;
          end
          if ((hit && mode_q) || (win_q == WIN_W'(LAST_WIN))) state_d = S_NEXT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          win_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      win_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      pat_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      win_q   <= win_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      pat_q   <= pat_d;
      mode_q  <= mode_d;
    end
  end

  assign busy_o        = (state_q == S_SCAN) || (state_q == S_NEXT);
  assign done_o        = (state_q == S_DONE);
  assign match_count_o = cnt_q;
  assign overflow_o    = ovf_q;

  // Counts wider than one digit clamp to a code the decoder renders as a dash.
  logic [3:0] disp_val;
  assign disp_val = (32'(cnt_q) > 9) ? 4'd15 : 4'(cnt_q);

  seg7_decoder u_seg (
    .din_i (disp_val),
    .a_o   (a_o),
    .b_o   (b_o),
    .c_o   (c_o),
    .d_o   (d_o),
    .e_o   (e_o),
    .f_o   (f_o),
    .g_o   (g_o)
  );

endmodule

// File: doc/pattern_scan_engine.md
PATTERN_SCAN_ENGINE -- requirements
Module: pattern_scan_engine

Interface
REQ-001 Parameters SHALL be: WORD_W, default 8, ROM word width; PAT_W, default 4, pattern width (PAT_W <= WORD_W); DEPTH, default 4, ROM words (power of 2, ADDR_W = log2(DEPTH)); COUNT_W, default 4, match counter width; TICK_DIV, default 1, clocks per window evaluation (1 = every cycle).
REQ-002 Ports SHALL be: clock  in  1  single system clock; all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; all state cleared while low.
REQ-004 start  in  1  one-cycle request to begin a scan; honoured only in IDLE.
REQ-005 mode  in  1  0 = count every matching window; 1 = count first match per word, then skip to next word.
REQ-006 pattern  in  PAT_W  search pattern; sampled at start and held internally for the scan.
REQ-007 wr_en / wr_addr / wr_data  in  1 / ADDR_W / WORD_W  ROM load port; write takes effect on the clock edge; ignored unless IDLE.
REQ-008 busy  out  1  high from the cycle after start acceptance until DONE is entered.
REQ-009 done  out  1  one-cycle pulse when a scan completes.
REQ-010 match_count  out  COUNT_W  matches found in the current/last scan.
REQ-011 overflow  out  1  sticky; set when a match occurs with match_count at its maximum.
REQ-012 a, b, c, d, e, f, g  out  1 each  seven-segment drive of match_count, active-low (0 = segment lit).

Function
REQ-013 Window k of a word (k = 0 .. WORD_W-PAT_W) SHALL be bits [k+PAT_W-1 : k]; a window matches when equal to the latched pattern.
REQ-014 FSM states SHALL be IDLE, SCAN, NEXT_WORD, DONE; reset state IDLE.
REQ-015 IDLE + start: latch pattern and mode, clear match_count and overflow, set address = 0 and window = 0, go to SCAN.
REQ-016 SCAN SHALL evaluate one window per tick (a tick occurs every TICK_DIV clocks; the tick divider restarts at start acceptance) and increment the window index after each evaluation.
REQ-017 In SCAN, a match SHALL increment match_count by 1, saturating at 2^COUNT_W-1 and setting overflow.
REQ-018 In SCAN, mode 1 with a match, or evaluation of the last window, SHALL go to NEXT_WORD.
REQ-019 NEXT_WORD SHALL take exactly one clock: if address = DEPTH-1 go to DONE, else increment address, clear window, return to SCAN.
REQ-020 DONE SHALL assert done for one clock and return to IDLE; match_count and the display hold until the next start.
REQ-021 start while not IDLE SHALL be ignored; wr_en while not IDLE SHALL be ignored.
REQ-022 Display SHALL decode match_count 0-9 as standard active-low segments (0: g=1, others 0; 1: a,d,e,f,g=1; 3: e,f=1; 8: all 0); values above 9 SHALL show "-" (g=0, a-f=1).
REQ-023 Display outputs SHALL be a combinational function of registered match_count (no added latency).

Reset
REQ-024 reset low SHALL force: FSM to IDLE, busy=0, done=0, match_count=0, overflow=0, address=0, window=0, tick divider=0, display showing 0 — including when reset is asserted mid-scan.
REQ-025 ROM contents SHALL be unaffected by reset; initial contents SHALL be the package defaults 8'hB3, 8'h55, 8'hDB, 8'hD1 for addresses 0-3 (zero for any further addresses).

Structure
REQ-026 A shared package SHALL hold the FSM state encoding, default parameter values and default ROM contents.
REQ-027 The seven-segment decoder SHALL be a separate sub-module, seg7_decoder, with a 4-bit input and outputs a-g.

Verification
REQ-028 Default ROM, TICK_DIV=1, mode 0, pattern 4'b0101, start -> match_count=3, display a=b=c=d=0, e=f=1, g=0; done pulses 24 clocks after start acceptance (20 SCAN + 4 NEXT_WORD).
REQ-029 Same with mode 1 -> match_count=1; pattern 4'b1011 -> mode 0 gives 3, mode 1 gives 2.
REQ-030 COUNT_W=2, write all words 8'hFF, pattern 4'b1111, mode 0 -> match_count=3, overflow=1, display shows 3.
REQ-031 TICK_DIV=4, pattern 4'b0101 -> one evaluation every 4 clocks; same final count 3; start and wr_en during busy have no effect.
REQ-032 Assert reset mid-scan after 2 matches -> all outputs at reset values; next start rescans from address 0.
REQ-033 Write 8'h0F to address 0 in IDLE, pattern 4'b1111, mode 0 -> match_count=1; reset does not alter the written word.
